pin_scan_decoder: RTL and testbench

// Receive end of the pin-scan blink protocol. Samples one board pin driven by a
// pin-scan blinker, finds the fast-toggle preamble, counts column pulses, the

---
 rtl/pin_scan_pkg.sv | 29 ++
 rtl/pin_scan_run_meter.sv | 107 ++++++++++
 rtl/pin_scan_decoder.sv | 196 +++++++++++++++++++
 tb/tb_pin_scan_decoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pin_scan_pkg.sv
// Shared types and constants for the pin-scan blink receiver.
// Contents:
//   scan_state_e - decoder FSM states
//   run_class_e  - classification of a finished (or idle-timed-out) pin run
//   SLOT_CLKS / HALF_SLOT / MAX_COUNT - transmitter slot timing and count limit
package pin_scan_pkg;

    localparam int SLOT_CLKS = 16;   // one pulse slot at the transmitter
    localparam int HALF_SLOT = 8;    // high or low half of a slot
    localparam int MAX_COUNT = 15;   // largest column/row value a frame can carry

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_PRE,
        ST_COL,
        ST_ROW,
        ST_DONE,
        ST_ERR
    } scan_state_e;

    typedef enum logic [2:0] {
        RC_SHORT,
        RC_PULSE,
        RC_GAP,
        RC_IDLE,
        RC_BAD
    } run_class_e;

endpackage

// File: rtl/pin_scan_run_meter.sv
// Synchronises the raw scan pin and measures how long it stays at each level.
// Every finished run is reported for one cycle with its level and class; a low
// run that lasts IDLE_MIN clocks is reported once as IDLE while still in progress.
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous, active-low
//   i_pin        in  raw pin, asynchronous to clk
//   o_run_valid  out 1-cycle strobe: a run report is present
//   o_run_level  out level of the reported run
//   o_run_class  out class of the reported run
module pin_scan_run_meter
    import pin_scan_pkg::*;
#(
    parameter int SHORT_MAX = 2,
    parameter int PULSE_MIN = 6,
    parameter int PULSE_MAX = 12,
    parameter int GAP_MIN   = 20,
    parameter int IDLE_MIN  = 256,
    parameter int RUN_W     = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_pin,
    output logic       o_run_valid,
    output logic       o_run_level,
    output run_class_e o_run_class
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [RUN_W-1:0] r_run_len;
    logic             r_idle_sent;
    logic             r_emit_valid;
    logic             r_emit_level;
    run_class_e       r_emit_class;

    logic w_edge;
    logic w_len_sat;
    logic w_idle_hit;

    function automatic run_class_e classify(input logic lvl, input logic [RUN_W-1:0] len);
        int n;
        n = int'(len);
        if (n <= SHORT_MAX)                           return RC_SHORT;
        if (n >= PULSE_MIN && n <= PULSE_MAX)         return RC_PULSE;
        if (!lvl && n >= GAP_MIN && n < IDLE_MIN)     return RC_GAP;
        return RC_BAD;
    endfunction

    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value; blocking here would collapse the synchroniser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    assign w_edge     = (r_sync2 != r_level);
    assign w_len_sat  = (r_run_len == '1);
    assign w_idle_hit = !r_level && !r_idle_sent && (r_run_len == RUN_W'(IDLE_MIN - 1));

    // r_run_len holds the cycles already spent at r_level, so at an edge it is
    // exactly the length of the run that just ended. A low run that already
    // reported IDLE stays silent when it finally ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level      <= 1'b0;
            r_run_len    <= '0;
            r_idle_sent  <= 1'b0;
            r_emit_valid <= 1'b0;
            r_emit_level <= 1'b0;
            r_emit_class <= RC_BAD;
        end else begin
            r_emit_valid <= 1'b0;
            if (w_edge) begin
                r_level     <= r_sync2;
                r_run_len   <= RUN_W'(1);
                r_idle_sent <= 1'b0;
                if (!r_idle_sent) begin
                    r_emit_valid <= 1'b1;
                    r_emit_level <= r_level;
                    r_emit_class <= classify(r_level, r_run_len);
                end
            end else begin
                if (!w_len_sat) begin
                    r_run_len <= r_run_len + 1'b1;
                end
                if (w_idle_hit) begin
                    r_idle_sent  <= 1'b1;
                    r_emit_valid <= 1'b1;
                    r_emit_level <= 1'b0;
                    r_emit_class <= RC_IDLE;
                end
            end
        end
    end

    assign o_run_valid = r_emit_valid;
    assign o_run_level = r_emit_level;
    assign o_run_class = r_emit_class;

endmodule

// File: rtl/pin_scan_decoder.sv
// Receive end of the pin-scan blink protocol: finds the fast-toggle preamble,
// counts column pulses, the pause, then row pulses, and reports (col,row) once
// per frame.
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous, active-low
//   pin_in       in  raw scanned pin
//   col_out      out last decoded column count
//   row_out      out last decoded row count
//   frame_valid  out 1-cycle pulse, col_out/row_out updated in the same cycle
//   frame_err    out 1-cycle pulse on a protocol violation
//   locked       out high from preamble acceptance until frame done/error
module pin_scan_decoder
    import pin_scan_pkg::*;
#(
    parameter int SHORT_MAX = 2,
    parameter int PULSE_MIN = 6,
    parameter int PULSE_MAX = 12,
    parameter int GAP_MIN   = 20,
    parameter int IDLE_MIN  = 256,
    parameter int PRE_MIN   = 8,
    parameter int RUN_W     = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pin_in,
    output logic [3:0] col_out,
    output logic [3:0] row_out,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       locked
);

    localparam int PRE_W = $clog2(PRE_MIN + 1);

    logic        w_run_valid;
    logic        w_run_level;
    run_class_e  w_run_class;

    scan_state_e      r_state;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [4:0]       r_col_cnt;
    logic [4:0]       r_row_cnt;
    logic [3:0]       r_col_out;
    logic [3:0]       r_row_out;
    logic             r_frame_valid;
    logic             r_frame_err;
    logic             r_locked;

    scan_state_e      w_state_nxt;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [4:0]       w_col_nxt;
    logic [4:0]       w_row_nxt;
    logic [4:0]       w_col_inc;
    logic [4:0]       w_row_inc;
    logic             w_hi_pulse;
    logic             w_lo_pulse;

    pin_scan_run_meter #(
        .SHORT_MAX (SHORT_MAX),
        .PULSE_MIN (PULSE_MIN),
        .PULSE_MAX (PULSE_MAX),
        .GAP_MIN   (GAP_MIN),
        .IDLE_MIN  (IDLE_MIN),
        .RUN_W     (RUN_W)
    ) u_meter (
        .clk         (clk),
        .reset       (reset),
        .i_pin       (pin_in),
        .o_run_valid (w_run_valid),
        .o_run_level (w_run_level),
        .o_run_class (w_run_class)
    );

    assign w_hi_pulse = w_run_level  && (w_run_class == RC_PULSE);
    assign w_lo_pulse = !w_run_level && (w_run_class == RC_PULSE);
    assign w_col_inc  = r_col_cnt + 5'd1;
    assign w_row_inc  = r_row_cnt + 5'd1;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre_cnt;
        w_col_nxt   = r_col_cnt;
        w_row_nxt   = r_row_cnt;
        case (r_state)
            ST_HUNT: begin
                if (w_run_valid) begin
                    if (w_run_class == RC_SHORT) begin
                        if (r_pre_cnt == PRE_W'(PRE_MIN - 1)) begin
                            w_state_nxt = ST_PRE;
                            w_pre_nxt   = '0;
                        end else begin
                            w_pre_nxt = r_pre_cnt + 1'b1;
                        end
                    end else begin
                        w_pre_nxt = '0;
                    end
                end
            end
            ST_PRE: begin
                if (w_run_valid && w_run_class != RC_SHORT) begin
                    if (w_lo_pulse) begin
                        w_state_nxt = ST_COL;
                        w_col_nxt   = '0;
                        w_row_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_COL: begin
                if (w_run_valid) begin
                    if (w_hi_pulse) begin
                        if (w_col_inc > 5'(MAX_COUNT)) w_state_nxt = ST_ERR;
                        else                           w_col_nxt   = w_col_inc;
                    end else if (w_lo_pulse) begin
                        w_state_nxt = ST_COL;
                    end else if (!w_run_level && w_run_class == RC_GAP) begin
                        // A pause with no column pulse before it is malformed.
                        w_state_nxt = (r_col_cnt == '0) ? ST_ERR : ST_ROW;
                    end else if (!w_run_level && w_run_class == RC_IDLE) begin
                        w_state_nxt = ST_DONE;
                        w_row_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_ROW: begin
                if (w_run_valid) begin
                    if (w_hi_pulse) begin
                        if (w_row_inc > 5'(MAX_COUNT)) w_state_nxt = ST_ERR;
                        else                           w_row_nxt   = w_row_inc;
                    end else if (w_lo_pulse) begin
                        w_state_nxt = ST_ROW;
                    end else if (!w_run_level && w_run_class == RC_IDLE) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_HUNT;
                w_pre_nxt   = '0;
            end
            ST_ERR: begin
                w_state_nxt = ST_HUNT;
                w_pre_nxt   = '0;
                w_col_nxt   = '0;
                w_row_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    // The pulse outputs and latched counts are registered on the transition
    // into DONE/ERR, so frame_valid and the new col/row appear together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_HUNT;
            r_pre_cnt     <= '0;
            r_col_cnt     <= '0;
            r_row_cnt     <= '0;
            r_col_out     <= '0;
            r_row_out     <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pre_cnt     <= w_pre_nxt;
            r_col_cnt     <= w_col_nxt;
            r_row_cnt     <= w_row_nxt;
            r_frame_valid <= (w_state_nxt == ST_DONE);
            r_frame_err   <= (w_state_nxt == ST_ERR);
            r_locked      <= (w_state_nxt == ST_PRE) || (w_state_nxt == ST_COL) ||
                             (w_state_nxt == ST_ROW);
            if (w_state_nxt == ST_DONE) begin
                r_col_out <= w_col_nxt[3:0];
                r_row_out <= w_row_nxt[3:0];
            end
        end
    end

    assign col_out     = r_col_out;
    assign row_out     = r_row_out;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign locked      = r_locked;

endmodule

// File: tb/tb_pin_scan_decoder.sv
// Directed bench for pin_scan_decoder: builds blink waveforms on pin_in clock
// by clock and checks the decoded frames, errors, lock flag and latency.
module tb_pin_scan_decoder;
    import pin_scan_pkg::*;

    localparam int IDLE_MIN = 256;
    localparam int PRE_OK   = 15;   // short runs in a good preamble, ends high

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pin_in = 1'b0;
    logic [3:0] col_out;
    logic [3:0] row_out;
    logic       frame_valid;
    logic       frame_err;
    logic       locked;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_fall   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int valid_cyc = 0;
    logic [3:0] cap_col [0:31];
    logic [3:0] cap_row [0:31];

    pin_scan_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .pin_in      (pin_in),
        .col_out     (col_out),
        .row_out     (row_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            cap_col[valid_cnt % 32] = col_out;
            cap_row[valid_cnt % 32] = row_out;
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds pin_in at lvl for n clocks.
    task automatic drive(input logic lvl, input int n);
        if (pin_in && !lvl) t_fall = cyc;
        pin_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pre(input int nrun);
        for (int i = 0; i < nrun; i++) drive((i % 2) == 0, 2);
    endtask

    // Low lead half-slot, columns, pause merged into last column low, rows.
    task automatic send_body(input int ncol, input int nrow, input int pauze);
        drive(1'b0, HALF_SLOT);
        for (int c = 0; c < ncol; c++) begin
            drive(1'b1, HALF_SLOT);
            if (c == ncol - 1 && nrow > 0) drive(1'b0, HALF_SLOT + pauze * SLOT_CLKS);
            else                           drive(1'b0, HALF_SLOT);
        end
        for (int r = 0; r < nrow; r++) begin
            drive(1'b1, HALF_SLOT);
            drive(1'b0, HALF_SLOT);
        end
    endtask

    int v0, e0, fs;

    initial begin
        // Reset state
        #23;
        check("rst_col", 32'(col_out), 0);
        check("rst_row", 32'(row_out), 0);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_locked", 32'(locked), 0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 20);

        // 1: col=7, pauze=3, row=5
        v0 = valid_cnt; e0 = err_cnt;
        send_pre(PRE_OK);
        check("t1_locked", 32'(locked), 1);
        send_body(7, 5, 3);
        drive(1'b0, 300);
        check("t1_valid_cnt", 32'(valid_cnt - v0), 1);
        check("t1_col", 32'(col_out), 7);
        check("t1_row", 32'(row_out), 5);
        check("t1_err_cnt", 32'(err_cnt - e0), 0);
        check("t1_unlocked", 32'(locked), 0);

        // 2: back-to-back 2048-clock frames (3,2) then (15,1)
        v0 = valid_cnt;
        fs = cyc;
        send_pre(PRE_OK);
        send_body(3, 2, 3);
        drive(1'b0, 2048 - (cyc - fs));
        fs = cyc;
        send_pre(PRE_OK);
        send_body(15, 1, 2);
        drive(1'b0, 2048 - (cyc - fs));
        check("t2_valid_cnt", 32'(valid_cnt - v0), 2);
        check("t2_col0", 32'(cap_col[v0 % 32]), 3);
        check("t2_row0", 32'(cap_row[v0 % 32]), 2);
        check("t2_col1", 32'(cap_col[(v0 + 1) % 32]), 15);
        check("t2_row1", 32'(cap_row[(v0 + 1) % 32]), 1);

        // 3: preamble too short -> nothing happens
        v0 = valid_cnt; e0 = err_cnt;
        send_pre(6);
        check("t3_nolock_pre", 32'(locked), 0);
        send_body(2, 2, 3);
        drive(1'b0, 300);
        check("t3_valid_cnt", 32'(valid_cnt - v0), 0);
        check("t3_err_cnt", 32'(err_cnt - e0), 0);

        // 4: second column pulse stretched to 20 clocks -> one error
        v0 = valid_cnt; e0 = err_cnt;
        send_pre(PRE_OK);
        drive(1'b0, HALF_SLOT);
        drive(1'b1, HALF_SLOT);
        drive(1'b0, HALF_SLOT);
        drive(1'b1, 20);
        drive(1'b0, HALF_SLOT);
        drive(1'b1, HALF_SLOT);
        drive(1'b0, 300);
        check("t4_err_cnt", 32'(err_cnt - e0), 1);
        check("t4_valid_cnt", 32'(valid_cnt - v0), 0);
        check("t4_col_held", 32'(col_out), 15);
        check("t4_row_held", 32'(row_out), 1);

        // 5: row=0 frame, latency from last falling edge
        v0 = valid_cnt;
        send_pre(PRE_OK);
        send_body(4, 0, 3);
        drive(1'b0, 300);
        check("t5_valid_cnt", 32'(valid_cnt - v0), 1);
        check("t5_col", 32'(col_out), 4);
        check("t5_row", 32'(row_out), 0);
        check("t5_latency", 32'(valid_cyc - t_fall), 32'(IDLE_MIN + 3));

        // 6: asynchronous reset mid-column, then a clean frame
        send_pre(PRE_OK);
        drive(1'b0, HALF_SLOT);
        drive(1'b1, HALF_SLOT);
        drive(1'b0, HALF_SLOT);
        pin_in = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        check("t6_rst_col", 32'(col_out), 0);
        check("t6_rst_row", 32'(row_out), 0);
        check("t6_rst_locked", 32'(locked), 0);
        pin_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        v0 = valid_cnt;
        drive(1'b0, 300);
        send_pre(PRE_OK);
        send_body(2, 3, 1);
        drive(1'b0, 300);
        check("t6_valid_cnt", 32'(valid_cnt - v0), 1);
        check("t6_col", 32'(col_out), 2);
        check("t6_row", 32'(row_out), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
